// File: rtl/i2c_bus_arbiter_pkg.sv
// Shared widths, state encoding and transaction record for the I2C bus arbiter.
package i2c_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_t;

    typedef struct packed {
        logic [I2C_ADDR_W-1:0] addr;
        logic                  rw;
        logic [I2C_DATA_W-1:0] wdata;
    } i2c_txn_t;

endpackage

// File: rtl/i2c_bus_arbiter_rr_pick.sv
// Round-robin winner select: first set request bit scanning upward from last+1.
module rr_pick #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] last,
    output logic [N_REQ-1:0]         win,
    output logic                     any
);

    localparam int LAST_W = $clog2(N_REQ);

    logic              found;
    logic [LAST_W-1:0] idx;

    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = LAST_W'((int'(last) + k) % N_REQ);
            if (!found && req[idx]) begin
                win[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one I2C master engine among N_REQ requesters,
// with a saturating watchdog that aborts transactions the master never finishes.
//
// state | meaning
// IDLE  | no owner; sample req and payloads, register the round-robin winner
// ISSUE | m_start pulse to the master, watchdog cleared
// WAIT  | waiting for m_done; watchdog counting toward TIMEOUT_CYCLES-1
// RESP  | req_done to the owner, pointer advances, grant released
module i2c_bus_arbiter
    import i2c_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ*I2C_ADDR_W-1:0] req_addr,
    input  logic [N_REQ-1:0]            req_rw,
    input  logic [N_REQ*I2C_DATA_W-1:0] req_wdata,
    output logic [N_REQ-1:0]            req_done,
    output logic [I2C_DATA_W-1:0]       req_rdata,
    output logic                        req_err,
    output logic [N_REQ-1:0]            grant,
    output logic                        m_start,
    output logic [I2C_ADDR_W-1:0]       m_addr,
    output logic                        m_rw,
    output logic [I2C_DATA_W-1:0]       m_wdata,
    output logic                        m_abort,
    input  logic                        m_done,
    input  logic [I2C_DATA_W-1:0]       m_rdata,
    input  logic                        m_nack
);

    localparam int LAST_W = $clog2(N_REQ);
    localparam int CNT_W  = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_t            state_q, state_d;
    logic [LAST_W-1:0]     last_q, last_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [N_REQ-1:0]      grant_q, grant_d;
    i2c_txn_t              txn_q, txn_d;
    logic [I2C_DATA_W-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic                  m_start_q, m_start_d;
    logic                  m_abort_q, m_abort_d;
    logic [N_REQ-1:0]      req_done_q, req_done_d;

    logic [N_REQ-1:0]      win;
    logic                  any;
    i2c_txn_t              win_txn;
    logic [LAST_W-1:0]     grant_idx;

    rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
        .req  (req),
        .last (last_q),
        .win  (win),
        .any  (any)
    );

    always_comb begin
        win_txn = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win[i]) begin
                win_txn.addr  = req_addr[i*I2C_ADDR_W +: I2C_ADDR_W];
                win_txn.rw    = req_rw[i];
                win_txn.wdata = req_wdata[i*I2C_DATA_W +: I2C_DATA_W];
            end
        end
    end

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_q[i]) grant_idx = LAST_W'(i);
        end
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        grant_d    = grant_q;
        txn_d      = txn_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        m_start_d  = 1'b0;
        m_abort_d  = 1'b0;
        req_done_d = '0;
        case (state_q)
            IDLE: begin
                if (any) begin
                    grant_d   = win;
                    txn_d     = win_txn;
                    m_start_d = 1'b1;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // m_done takes priority over a watchdog expiry in the same cycle
                if (m_done) begin
                    rdata_d    = m_rdata;
                    err_d      = m_nack;
                    req_done_d = grant_q;
                    state_d    = RESP;
                end else if (cnt_q == CNT_MAX) begin
                    m_abort_d = 1'b1;
                    err_d     = 1'b1;
                    rdata_d   = '0;
                    state_d   = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                // after a timeout, RESP lasts one extra cycle so m_abort leads req_done
                if (m_abort_q) begin
                    req_done_d = grant_q;
                end else begin
                    last_d  = grant_idx;
                    grant_d = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_q     <= LAST_W'(N_REQ - 1);
            cnt_q      <= '0;
            grant_q    <= '0;
            txn_q      <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            m_start_q  <= 1'b0;
            m_abort_q  <= 1'b0;
            req_done_q <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            grant_q    <= grant_d;
            txn_q      <= txn_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            m_start_q  <= m_start_d;
            m_abort_q  <= m_abort_d;
            req_done_q <= req_done_d;
        end
    end

    assign grant     = grant_q;
    assign req_done  = req_done_q;
    assign req_rdata = rdata_q;
    assign req_err   = err_q;
    assign m_start   = m_start_q;
    assign m_abort   = m_abort_q;
    assign m_addr    = txn_q.addr;
    assign m_rw      = txn_q.rw;
    assign m_wdata   = txn_q.wdata;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Bench for i2c_bus_arbiter: transaction-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized requesters and master.
module tb_i2c_bus_arbiter;

    localparam int N  = 4;
    localparam int T  = 16;
    localparam int AW = N * 7;
    localparam int DW = N * 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  req = '0;
    logic [AW-1:0] req_addr = '0;
    logic [N-1:0]  req_rw = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [N-1:0]  req_done;
    logic [7:0]    req_rdata;
    logic          req_err;
    logic [N-1:0]  grant;
    logic          m_start;
    logic [6:0]    m_addr;
    logic          m_rw;
    logic [7:0]    m_wdata;
    logic          m_abort;
    logic          m_done = 1'b0;
    logic [7:0]    m_rdata = '0;
    logic          m_nack = 1'b0;

    int assertions = 0;
    int failures   = 0;
    int cyc        = 0;
    int done_cnt   = 0;
    int abort_cnt  = 0;
    bit started    = 1'b0;

    int         resp_mode  = 1;   // 0 random delay, 1 fixed delay, 2 never respond
    int         resp_delay = 10;
    logic [7:0] resp_rdata = '0;
    logic       resp_nack  = 1'b0;

    logic [N-1:0] exp_grant = '0;
    logic [N-1:0] exp_done  = '0;
    logic [7:0]   exp_rdata = '0;
    logic         exp_err   = 1'b0;
    logic         exp_start = 1'b0;
    logic         exp_abort = 1'b0;
    logic [6:0]   exp_addr  = '0;
    logic         exp_rw    = 1'b0;
    logic [7:0]   exp_wdata = '0;
    int           mlast     = N - 1;

    i2c_bus_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(T)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_addr  (req_addr),
        .req_rw    (req_rw),
        .req_wdata (req_wdata),
        .req_done  (req_done),
        .req_rdata (req_rdata),
        .req_err   (req_err),
        .grant     (grant),
        .m_start   (m_start),
        .m_addr    (m_addr),
        .m_rw      (m_rw),
        .m_wdata   (m_wdata),
        .m_abort   (m_abort),
        .m_done    (m_done),
        .m_rdata   (m_rdata),
        .m_nack    (m_nack)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (req_done != '0) done_cnt <= done_cnt + 1;
        if (m_abort) abort_cnt <= abort_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertions++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++)
            if (r[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    function automatic int onehot_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++)
            if (v[i]) return i;
        return -1;
    endfunction

    // Reference model: one pass of the loop is one whole transaction.
    task automatic tick(output bit r);
        @(posedge clk);
        r = rst;
        if (rst) begin
            exp_grant = '0; exp_done = '0; exp_rdata = '0; exp_err = 1'b0;
            exp_start = 1'b0; exp_abort = 1'b0; exp_addr = '0; exp_rw = 1'b0;
            exp_wdata = '0; mlast = N - 1;
        end
    endtask

    initial begin : ref_model
        bit r;
        int g;
        int n;
        int outcome;
        forever begin
            tick(r);
            if (r || req == '0) continue;
            g = pick(req, mlast);
            exp_grant    = '0;
            exp_grant[g] = 1'b1;
            exp_addr     = req_addr[g*7 +: 7];
            exp_rw       = req_rw[g];
            exp_wdata    = req_wdata[g*8 +: 8];
            exp_start    = 1'b1;
            tick(r);
            if (r) continue;
            exp_start = 1'b0;
            n = 0;
            outcome = 0;
            while (outcome == 0) begin
                tick(r);
                if (r) break;
                if (m_done) begin
                    exp_rdata = m_rdata; exp_err = m_nack; exp_done = exp_grant; outcome = 1;
                end else if (n == T - 1) begin
                    exp_abort = 1'b1; exp_err = 1'b1; exp_rdata = '0; outcome = 2;
                end else begin
                    n++;
                end
            end
            if (r) continue;
            if (outcome == 2) begin
                tick(r);
                if (r) continue;
                exp_abort = 1'b0;
                exp_done  = exp_grant;
            end
            tick(r);
            if (r) continue;
            exp_done  = '0;
            exp_grant = '0;
            mlast     = g;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("grant", grant, exp_grant);
            chk("req_done", req_done, exp_done);
            chk("req_rdata", req_rdata, exp_rdata);
            chk("req_err", req_err, exp_err);
            chk("m_start", m_start, exp_start);
            chk("m_abort", m_abort, exp_abort);
            chk("m_addr", m_addr, exp_addr);
            chk("m_rw", m_rw, exp_rw);
            chk("m_wdata", m_wdata, exp_wdata);
        end
    end

    initial begin : master_model
        int dly;
        forever begin
            @(negedge clk);
            if (m_start && resp_mode != 2) begin
                dly = (resp_mode == 1) ? resp_delay : $urandom_range(1, 20);
                repeat (dly) @(posedge clk);
                #1;
                m_done  = 1'b1;
                m_rdata = (resp_mode == 1) ? resp_rdata : 8'($urandom);
                m_nack  = (resp_mode == 1) ? resp_nack : 1'($urandom);
                @(posedge clk);
                #1;
                m_done = 1'b0;
            end
        end
    end

    // which: 0 = m_start, 1 = any req_done, 2 = m_abort
    task automatic wait_for(input int which, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((which == 0 && m_start) || (which == 1 && req_done != '0) ||
                (which == 2 && m_abort)) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            assertions++;
            failures++;
            $display("FAIL wait_%0d: no event within %0d cycles", which, budget);
        end
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic idle_gap(input int n);
        @(posedge clk);
        #1;
        req = '0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin : main
        int t0, s, d, a, ab0, dc0;
        int order[5];
        int exp_order[5] = '{0, 1, 2, 3, 0};

        chk("pick_1111_l3", pick(4'b1111, 3), 0);
        chk("pick_1111_l0", pick(4'b1111, 0), 1);
        chk("pick_1001_l0", pick(4'b1001, 0), 3);
        chk("pick_0001_l2", pick(4'b0001, 2), 0);
        chk("pick_0110_l2", pick(4'b0110, 2), 1);

        @(posedge clk);
        #1;
        started = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_grant", grant, 0);
        chk("rst_done", req_done, 0);
        chk("rst_start", m_start, 0);
        chk("rst_abort", m_abort, 0);
        chk("rst_addr", m_addr, 0);
        chk("rst_wdata", m_wdata, 0);

        // single requester write
        @(posedge clk);
        #1;
        req = 4'b0001; req_addr[6:0] = 7'h50; req_wdata[7:0] = 8'hA5; req_rw = '0;
        resp_mode = 1; resp_delay = 10; resp_nack = 1'b0; resp_rdata = 8'h77;
        t0 = cyc;
        wait_for(0, 10, s);
        chk("single_start_lat", s - t0, 1);
        chk("single_addr", m_addr, 7'h50);
        chk("single_wdata", m_wdata, 8'hA5);
        chk("single_grant", grant, 4'b0001);
        wait_for(1, 40, d);
        chk("single_done_lat", d - s, 11);
        chk("single_done", req_done, 4'b0001);
        chk("single_err", req_err, 0);
        idle_gap(5);

        // round-robin fairness from a fresh reset
        do_reset(2);
        req = 4'b1111; resp_mode = 1; resp_delay = 3;
        for (int k = 0; k < 5; k++) begin
            wait_for(0, 60, s);
            order[k] = onehot_idx(grant);
        end
        idle_gap(30);
        for (int k = 0; k < 5; k++) chk($sformatf("rr_order_%0d", k), order[k], exp_order[k]);

        // read with NACK from requester 2
        req = 4'b0100; req_rw = 4'b0100; req_addr[20:14] = 7'h21;
        resp_mode = 1; resp_delay = 5; resp_rdata = 8'h3C; resp_nack = 1'b1;
        wait_for(0, 20, s);
        chk("nack_rw", m_rw, 1);
        chk("nack_addr", m_addr, 7'h21);
        wait_for(1, 40, d);
        chk("nack_done", req_done, 4'b0100);
        chk("nack_rdata", req_rdata, 8'h3C);
        chk("nack_err", req_err, 1);
        idle_gap(5);

        // watchdog timeout
        req = 4'b1000; resp_mode = 2;
        wait_for(0, 20, s);
        chk("to_grant", grant, 4'b1000);
        wait_for(2, 40, a);
        chk("to_abort_lat", a - s, 17);
        wait_for(1, 5, d);
        chk("to_done_after_abort", d - a, 1);
        chk("to_done", req_done, 4'b1000);
        chk("to_err", req_err, 1);
        chk("to_rdata", req_rdata, 0);
        idle_gap(5);

        // m_done coincides with watchdog expiry
        ab0 = abort_cnt;
        req = 4'b0010; resp_mode = 1; resp_delay = 16; resp_rdata = 8'h5A; resp_nack = 1'b1;
        wait_for(0, 20, s);
        wait_for(1, 40, d);
        chk("simul_done_lat", d - s, 17);
        chk("simul_done", req_done, 4'b0010);
        chk("simul_err", req_err, 1);
        chk("simul_rdata", req_rdata, 8'h5A);
        idle_gap(5);
        chk("simul_no_abort", abort_cnt - ab0, 0);

        // reset while waiting on the master
        req = 4'b0100; resp_mode = 2;
        wait_for(0, 20, s);
        chk("rstw_grant", grant, 4'b0100);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1; req = 4'b1111; resp_mode = 1; resp_delay = 4; resp_nack = 1'b0;
        dc0 = done_cnt;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rstw_grant0", grant, 0);
        chk("rstw_done0", req_done, 0);
        chk("rstw_start0", m_start, 0);
        chk("rstw_addr0", m_addr, 0);
        chk("rstw_wdata0", m_wdata, 0);
        chk("rstw_rdata0", req_rdata, 0);
        chk("rstw_err0", req_err, 0);
        wait_for(0, 10, s);
        chk("rstw_first_grant", grant, 4'b0001);
        @(posedge clk);
        #1;
        chk("rstw_no_done", done_cnt - dc0, 0);
        idle_gap(30);

        // randomized requesters, master latency and occasional reset
        resp_mode = 0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            rst = ($urandom_range(0, 599) == 0);
            for (int i = 0; i < N; i++) begin
                if (req[i] && req_done[i]) req[i] = 1'($urandom_range(0, 1));
                else if (!req[i]) req[i] = ($urandom_range(0, 3) == 0);
                else if ($urandom_range(0, 39) == 0) req[i] = 1'b0;
            end
            req_addr  = AW'({$urandom, $urandom});
            req_wdata = DW'($urandom);
            req_rw    = N'($urandom);
        end
        rst = 1'b0;
        idle_gap(40);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
